// File: rtl/minione_pkg.sv
// Shared definitions for the minione CPU: opcodes, instruction word layout
// and the fetch-stage state encoding.
package minione_pkg;

   localparam int INSTR_W = 24;

   localparam logic [7:0] OP_LD   = 8'd0;
   localparam logic [7:0] OP_ADD  = 8'd1;
   localparam logic [7:0] OP_SUB  = 8'd2;
   localparam logic [7:0] OP_AND  = 8'd3;
   localparam logic [7:0] OP_OR   = 8'd4;
   localparam logic [7:0] OP_XOR  = 8'd5;
   localparam logic [7:0] OP_ST   = 8'd6;
   localparam logic [7:0] OP_LDR  = 8'd7;
   localparam logic [7:0] OP_SKLT = 8'd9;
   localparam logic [7:0] OP_JMP  = 8'd11;

   typedef struct packed {
      logic [7:0] sel;
      logic [7:0] op1;
      logic [7:0] op2;
   } instr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/minione_fetch_if.sv
// Bus bundle between the fetch stage, program memory and the execute core.
interface minione_fetch_if #(
   parameter int PC_W = 16
);
   import minione_pkg::*;

   // Handshakes: imem_req is a level held until imem_rvalid (one request in
   // flight, imem_addr stable meanwhile); an instruction transfers on any
   // cycle where ins_valid && ins_ready, and ins_* hold while stalled.
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               ins_valid;
   logic               ins_ready;
   logic [7:0]         ins_sel;
   logic [7:0]         ins_op1;
   logic [7:0]         ins_op2;
   logic [PC_W-1:0]    ins_pc;
   logic               redir_valid;
   logic [PC_W-1:0]    redir_pc;

   modport master (
      output imem_req, imem_addr,
      input  imem_rvalid, imem_rdata,
      output ins_valid, ins_sel, ins_op1, ins_op2, ins_pc,
      input  ins_ready,
      input  redir_valid, redir_pc
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rvalid, imem_rdata,
      input  ins_valid, ins_sel, ins_op1, ins_op2, ins_pc,
      output ins_ready,
      output redir_valid, redir_pc
   );

endinterface

// File: rtl/minione_ibuf.sv
// Two-entry instruction queue; the head entry drives the core-facing outputs
// directly from registers.
module minione_ibuf
   import minione_pkg::*;
#(
   parameter int PC_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  instr_t          push_ins,
   input  logic [PC_W-1:0] push_pc,
   input  logic            pop,
   input  logic            flush,
   output logic [1:0]      count,
   output logic            head_valid,
   output instr_t          head_ins,
   output logic [PC_W-1:0] head_pc
);

   instr_t          head_ins_q, tail_ins_q;
   logic [PC_W-1:0] head_pc_q, tail_pc_q;
   logic [1:0]      count_q;
   logic            do_pop, do_push;
   logic [1:0]      base;

   assign do_pop  = pop && (count_q != 2'd0);
   assign base    = count_q - {1'b0, do_pop};
   assign do_push = push && (base < 2'd2);

   // The push slot is chosen after the pop shift, so push+pop on a full
   // queue lands the new word in the tail while the old tail moves up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ins_q <= '0;
         tail_ins_q <= '0;
         head_pc_q  <= '0;
         tail_pc_q  <= '0;
         count_q    <= 2'd0;
      end else if (flush) begin
         count_q <= 2'd0;
      end else begin
         if (do_pop) begin
            head_ins_q <= tail_ins_q;
            head_pc_q  <= tail_pc_q;
         end
         if (do_push) begin
            if (base == 2'd0) begin
               head_ins_q <= push_ins;
               head_pc_q  <= push_pc;
            end else begin
               tail_ins_q <= push_ins;
               tail_pc_q  <= push_pc;
            end
         end
         count_q <= base + {1'b0, do_push};
      end
   end

   assign count      = count_q;
   assign head_valid = (count_q != 2'd0);
   assign head_ins   = head_ins_q;
   assign head_pc    = head_pc_q;

endmodule

// File: rtl/minione_fetch.sv
// minione instruction fetch: one outstanding program-memory read at a time,
// results queued in minione_ibuf, redirects flush queue and in-flight read.
module minione_fetch
   import minione_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   minione_fetch_if.master bus,
   output fetch_state_e    dbg_state
);

   localparam logic [2:0]      DEPTH_C = 3'(DEPTH);
   localparam logic [PC_W-1:0] PC_ONE  = 1;

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] target_q, target_d;
   logic            push, pop, flush;
   logic [1:0]      count;
   logic [2:0]      post_cnt;
   logic            head_valid;
   instr_t          head_ins;
   logic [PC_W-1:0] head_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         target_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
      end
   end

   assign pop      = head_valid && bus.ins_ready;
   assign flush    = bus.redir_valid;
   assign post_cnt = {1'b0, count} - {2'b00, pop} + 3'd1;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      target_d = target_q;
      push     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.redir_valid) begin
               pc_d = bus.redir_pc;
               if (run) state_d = FETCH;
            end else if (run && ({1'b0, count} < DEPTH_C)) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (bus.imem_rvalid) begin
               if (bus.redir_valid) begin
                  pc_d = bus.redir_pc;
                  if (!run) state_d = IDLE;
               end else begin
                  push = 1'b1;
                  pc_d = pc_q + PC_ONE;
                  if (!run || (post_cnt >= DEPTH_C)) state_d = IDLE;
               end
            end else if (bus.redir_valid) begin
               target_d = bus.redir_pc;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            // The stale read still has to complete before a new request.
            if (bus.redir_valid) target_d = bus.redir_pc;
            if (bus.imem_rvalid) begin
               pc_d    = bus.redir_valid ? bus.redir_pc : target_q;
               state_d = run ? FETCH : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   minione_ibuf #(.PC_W(PC_W)) u_ibuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_ins   (instr_t'(bus.imem_rdata)),
      .push_pc    (pc_q),
      .pop        (pop),
      .flush      (flush),
      .count      (count),
      .head_valid (head_valid),
      .head_ins   (head_ins),
      .head_pc    (head_pc)
   );

   assign bus.imem_req  = (state_q == FETCH);
   assign bus.imem_addr = pc_q;
   assign bus.ins_valid = head_valid;
   assign bus.ins_sel   = head_ins.sel;
   assign bus.ins_op1   = head_ins.op1;
   assign bus.ins_op2   = head_ins.op2;
   assign bus.ins_pc    = head_pc;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_minione_fetch.sv
// Bench for minione_fetch: memory model with variable latency, a random core
// (ready/redirect), and a scoreboard of the expected instruction stream.
module tb_minione_fetch;
   import minione_pkg::*;

   localparam int PC_W = 16;
   localparam int EW   = PC_W + INSTR_W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         run;
   fetch_state_e dbg_state;

   minione_fetch_if #(.PC_W(PC_W)) bus ();

   minione_fetch #(.PC_W(PC_W), .RESET_PC(16'h0000), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .bus       (bus.master),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int            total_cnt = 0;
   int            pass_cnt  = 0;
   int            hs_cnt    = 0;
   int            lat_fixed = 1;
   logic [EW-1:0] exp_q[$];
   logic [PC_W-1:0] gen_pc;

   function automatic logic [23:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 24'h000A00;
         16'h0001: return 24'h010F16;
         16'h0002: return 24'h022108;
         default:  return {a[7:0] ^ 8'hA5, a[15:8] + 8'h3C, a[7:0]};
      endcase
   endfunction

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: after reset or redirect to P the core must see P, P+1, ...
   task automatic top_up();
      while (exp_q.size() < 16) begin
         exp_q.push_back({gen_pc, mem_word(gen_pc)});
         gen_pc += 16'd1;
      end
   endtask

   task automatic refill(input logic [15:0] p);
      exp_q.delete();
      gen_pc = p;
      top_up();
   endtask

   task automatic tick();
      @(posedge clk);
      top_up();
      #2;
   endtask

   task automatic redirect(input logic [15:0] t);
      bus.redir_valid = 1'b1;
      bus.redir_pc    = t;
      @(posedge clk);
      refill(t);
      #2;
      bus.redir_valid = 1'b0;
   endtask

   // Program memory: one read at a time, latency counted from the first
   // cycle the request is seen.
   initial begin
      logic            busy;
      int              rem;
      logic [PC_W-1:0] req_addr;
      busy = 1'b0;
      rem = 0;
      req_addr = '0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = 24'($urandom);
         if (!rst_n) begin
            busy = 1'b0;
         end else if (busy) begin
            rem--;
            if (rem == 0) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = mem_word(req_addr);
               busy = 1'b0;
            end
         end else if (bus.imem_req) begin
            busy = 1'b1;
            req_addr = bus.imem_addr;
            rem = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
         end
      end
   end

   // Monitor: checks every accepted instruction and output stability.
   initial begin
      logic          prev_stall;
      logic [EW-1:0] prev_out, cur, exp;
      prev_stall = 1'b0;
      prev_out = '0;
      forever begin
         @(negedge clk);
         cur = {bus.ins_pc, bus.ins_sel, bus.ins_op1, bus.ins_op2};
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && bus.ins_valid) check("hold", cur, prev_out);
            if (bus.ins_valid && bus.ins_ready) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  total_cnt++;
                  $display("FAIL stream: got %h expected none", cur);
               end else begin
                  exp = exp_q.pop_front();
                  check("stream", cur, exp);
               end
            end
            prev_stall = bus.ins_valid && !bus.ins_ready;
            prev_out = cur;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            n;
      logic          found;
      logic [23:0]   w;
      logic [15:0]   t;
      rst_n = 1'b0;
      run = 1'b0;
      bus.ins_ready = 1'b0;
      bus.redir_valid = 1'b0;
      bus.redir_pc = '0;
      refill(16'h0000);
      repeat (3) tick();
      check("rst_imem_req", bus.imem_req, 0);
      check("rst_imem_addr", bus.imem_addr, 0);
      check("rst_ins_valid", bus.ins_valid, 0);
      check("rst_ins_fields", {bus.ins_pc, bus.ins_sel, bus.ins_op1, bus.ins_op2}, 0);
      check("rst_state", dbg_state, IDLE);
      rst_n = 1'b1;
      tick();
      check("idle_no_req", bus.imem_req, 0);

      // First-fetch latency and back-pressure with the core stalled.
      run = 1'b1;
      n = 0;
      found = 1'b0;
      while (n < 10 && !found) begin
         tick();
         n++;
         found = bus.ins_valid;
      end
      check("first_valid_latency", n, 3);
      repeat (10) tick();
      check("full_imem_req", bus.imem_req, 0);
      check("full_imem_addr", bus.imem_addr, 2);
      check("full_head", {bus.ins_pc, bus.ins_sel, bus.ins_op1, bus.ins_op2}, {16'h0000, 24'h000A00});
      bus.ins_ready = 1'b1;
      repeat (20) tick();

      // Redirect coincident with read data.
      n = 0;
      found = 1'b0;
      while (n < 20 && !found) begin
         tick();
         n++;
         found = bus.imem_rvalid;
      end
      check("rvalid_seen", found, 1);
      redirect(16'h0010);
      check("coinc_ins_valid", bus.ins_valid, 0);
      check("coinc_imem_addr", bus.imem_addr, 16'h0010);
      check("coinc_imem_req", bus.imem_req, 1);
      repeat (10) tick();

      // PC wrap.
      redirect(16'hFFFF);
      repeat (12) tick();

      // Asynchronous reset with a request outstanding and one word queued.
      rst_n = 1'b0;
      tick();
      tick();
      bus.ins_ready = 1'b0;
      refill(16'h0000);
      rst_n = 1'b1;
      n = 0;
      found = 1'b0;
      while (n < 20 && !found) begin
         tick();
         n++;
         found = bus.ins_valid && bus.imem_req;
      end
      check("pre_reset_state_seen", found, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_imem_req", bus.imem_req, 0);
      check("async_rst_ins_valid", bus.ins_valid, 0);
      check("async_rst_imem_addr", bus.imem_addr, 0);
      tick();
      tick();
      lat_fixed = 3;
      bus.ins_ready = 1'b1;
      refill(16'h0000);
      rst_n = 1'b1;

      // Redirect while a slow read to address 1 is in flight.
      n = 0;
      found = 1'b0;
      while (n < 30 && !found) begin
         tick();
         n++;
         found = bus.imem_req && (bus.imem_addr == 16'h0001);
      end
      check("req_addr1_seen", found, 1);
      tick();
      redirect(16'h0003);
      n = 0;
      found = 1'b0;
      while (n < 30 && !found) begin
         tick();
         n++;
         found = bus.ins_valid;
      end
      w = mem_word(16'h0003);
      check("drain_next_valid", found, 1);
      check("drain_next_pc", bus.ins_pc, 16'h0003);
      check("drain_next_sel", bus.ins_sel, w[23:16]);
      repeat (10) tick();

      // Random traffic.
      lat_fixed = 0;
      for (int i = 0; i < 2000; i++) begin
         bus.ins_ready = ($urandom_range(0, 9) < 7);
         run = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 29) == 0) begin
            if ($urandom_range(0, 3) == 0) t = 16'hFFFE + 16'($urandom_range(0, 1));
            else t = 16'($urandom_range(0, 65535));
            redirect(t);
         end else begin
            tick();
         end
      end
      run = 1'b1;
      bus.ins_ready = 1'b1;
      repeat (20) tick();
      check("progress", (hs_cnt > 100), 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/minione_fetch.md
# minione_fetch

Instruction fetch stage for the minione CPU. Reads 24-bit instruction words `{sel, op1, op2}` from program memory at the current PC and buffers them in a 2-entry queue. Presents them to the minione execute core over a valid/ready handshake. Accepts redirects (JMP, taken skip) from the core, flushing buffered and in-flight instructions.

## Interface

Parameters:
- `PC_W`, 16, program counter width
- `RESET_PC`, 0, PC value after reset
- `DEPTH`, 2, instruction buffer entries (fixed at 2 for this revision)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; one clock, asynchronous and active-low
- `run`  in  1  fetch enable; 0 stops issuing new requests
- `imem_req`  out  1  fetch request, level, held until `imem_rvalid`
- `imem_addr`  out  PC_W  fetch address, stable while `imem_req`=1
- `imem_rvalid`  in  1  read data valid, earliest the cycle after `imem_req` rises
- `imem_rdata`  in  24  instruction word: [23:16] sel, [15:8] op1, [7:0] op2
- `ins_valid`  out  1  head of buffer holds a valid instruction
- `ins_ready`  in  1  core accepts the instruction
- `ins_sel`  out  8  function select
- `ins_op1`  out  8  operand 1
- `ins_op2`  out  8  operand 2
- `ins_pc`  out  PC_W  address the instruction was fetched from
- `redir_valid`  in  1  core requests a PC change this cycle
- `redir_pc`  in  PC_W  new fetch address

## Operation

- At most one memory request outstanding. `imem_req` is 1 exactly in state FETCH.
- States:
  - IDLE → FETCH when `run`=1 and count<DEPTH.
  - FETCH:
    - on `imem_rvalid`: push word with `ins_pc`=pc, then pc←pc+1 (mod 2^PC_W). Next state is FETCH if `run` and post-push count<DEPTH, else IDLE.
    - on `redir_valid` without `imem_rvalid`: latch target, go to DRAIN.
  - DRAIN: the next `imem_rvalid` is discarded. Then pc←target and go to FETCH if `run`, else IDLE. A new redirect in DRAIN overwrites the target.
- Redirect rules:
  - Redirect in IDLE: pc←`redir_pc`, buffer flushed.
  - Redirect coincident with `imem_rvalid` in FETCH: word dropped (no push), pc←`redir_pc`, stay FETCH if `run`.
  - Every redirect flushes the buffer the same cycle. Flush overrides push and pop.
  - An instruction handshaked in the same cycle as `redir_valid` is still consumed by the core. That is the core's redirecting instruction.
- Buffer:
  - pop when `ins_valid`&&`ins_ready`; push and pop in the same cycle allowed.
  - Outputs are driven from the head entry; `ins_*` hold while `ins_valid`=1 and `ins_ready`=0.
- `run` falling mid-FETCH: the outstanding request completes and its word is pushed, then IDLE.
- PC arithmetic is unsigned, wraps 2^PC_W−1 → 0.

## Timing

- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `ins_valid`=0, `ins_sel`/`ins_op1`/`ins_op2`=0, `ins_pc`=0, count=0, state IDLE.
- `imem_addr` = pc register. `imem_req` is decoded from the state register, with no combinational path from inputs.
- Zero-wait memory, empty buffer: `run` rises at cycle N → `imem_req` at N+1 → `imem_rvalid` at N+2 → `ins_valid` at N+3.
- Redirect sampled at cycle R with no request outstanding: `imem_req`/`imem_addr`=`redir_pc` at R+1, first new `ins_valid` at R+3 (zero-wait).
- Redirect with a request outstanding adds the remaining memory latency before the new request issues.
- Steady state with zero-wait memory and `ins_ready`=1: one instruction per 2 cycles.

## Structure

- Shared package `minione_pkg`:
  - opcode constants: OP_LD=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_ST=6, OP_LDR=7, OP_SKLT=9, OP_JMP=11
  - `INSTR_W`=24
  - packed instruction type `{sel, op1, op2}`
  - fetch state enum {IDLE, FETCH, DRAIN}
- Sub-module `minione_ibuf`: 2-entry FIFO with push/pop/flush, count, head data + pc. The FSM and PC stay in `minione_fetch`.

## Test plan

- Reset, `run`=1, zero-wait memory holding 0x000A00 @0, 0x010F16 @1, 0x022108 @2, `ins_ready`=1 → instructions in order, `ins_pc`=0,1,2, first `ins_valid` 3 cycles after `run`.
- `ins_ready`=0 → two words buffered, `imem_req` drops with `imem_addr`=2, `ins_*` stable. Raise `ins_ready` → fetch resumes at 2.
- Memory latency 3, `redir_valid` with `redir_pc`=3 one cycle after request to addr 1 → word @1 never appears, next `ins_pc`=3, `ins_sel`=mem[3][23:16].
- `redir_valid` (`redir_pc`=0x10) in the same cycle as `imem_rvalid` → no push, buffer empty next cycle, next `imem_addr`=0x10.
- `redir_pc`=0xFFFF → `ins_pc` sequence 0xFFFF, 0x0000.
- `rst_n` asserted while `imem_req`=1 with 1 entry buffered → immediately `imem_req`=0, `ins_valid`=0, `imem_addr`=0. After release, fetch restarts at 0.
